// File: rtl/lsu_byte_merge_if.sv
// Request, response and memory-side signal bundle for lsu_byte_merge.
// The slave modport is the unit; the master modport is the pipeline plus the word memory.
interface lsu_byte_merge_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic                  req_half_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [15:0]           req_wdata_i;
    logic                  resp_valid_o;
    logic [15:0]           resp_rdata_o;
    logic                  misalign_o;
    logic                  oor_o;
    logic [15:0]           mem_addr_o;
    logic [15:0]           mem_data_o;
    logic                  mem_write_o;
    logic                  mem_read_o;
    logic [15:0]           mem_rdata_i;

    modport slave (
        input  req_valid_i, req_we_i, req_half_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, misalign_o, oor_o,
        output mem_addr_o, mem_data_o, mem_write_o, mem_read_o
    );

    modport master (
        output req_valid_i, req_we_i, req_half_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, misalign_o, oor_o,
        input  mem_addr_o, mem_data_o, mem_write_o, mem_read_o
    );
endinterface

// File: rtl/lsu_byte_merge.sv
// Byte-addressed load/store front end for a 16-bit word memory (read-modify-write byte stores).
// Define LSU_ACCESS_CNT_EN to add the load/store access counters.
module lsu_byte_merge #(
    parameter int MEM_WORDS  = 8192,
    parameter int ADDR_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    lsu_byte_merge_if.slave    bus
`ifdef LSU_ACCESS_CNT_EN
    ,
    output logic [15:0]        load_cnt_o,
    output logic [15:0]        store_cnt_o
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic                  half_q, half_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [15:0]           rdata_q, rdata_d;
    logic                  misalign_q, misalign_d;
    logic                  oor_q, oor_d;

    logic                  ready_s;
    logic                  mem_read_s;
    logic                  mem_write_s;
    logic [15:0]           mem_addr_s;
    logic [15:0]           mem_data_s;
    logic [ADDR_WIDTH-1:0] req_idx_s;
    logic                  req_misalign_s;
    logic                  req_oor_s;

    function automatic logic [15:0] word_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] idx;
        idx = {1'b0, a[ADDR_WIDTH-1:1]};
        return 16'(idx);
    endfunction

    function automatic logic [15:0] load_extend(input logic [15:0] word, input logic half,
                                                input logic uns, input logic hi);
        logic [7:0]  b;
        logic [15:0] res;
        b = hi ? word[15:8] : word[7:0];
        if (half) begin
            res = word;
        end else if (uns) begin
            res = {8'h00, b};
        end else begin
            res = {{8{b[7]}}, b};
        end
        return res;
    endfunction

    // Little-endian: the odd byte of an address pair lives in bits [15:8].
    function automatic logic [15:0] byte_merge(input logic [15:0] word, input logic [7:0] b,
                                               input logic hi);
        return hi ? {b, word[7:0]} : {word[15:8], b};
    endfunction

    assign req_idx_s      = {1'b0, bus.req_addr_i[ADDR_WIDTH-1:1]};
    assign req_misalign_s = bus.req_half_i & bus.req_addr_i[0];
    assign req_oor_s      = (32'(req_idx_s) >= 32'(MEM_WORDS));

    // State register, request latches and registered response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            half_q     <= 1'b0;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= 16'h0000;
            rdata_q    <= 16'h0000;
            misalign_q <= 1'b0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            half_q     <= half_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            oor_q      <= oor_d;
        end
    end

    // Next-state, latch capture and memory-side decode.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        half_d      = half_q;
        uns_d       = uns_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        misalign_d  = misalign_q;
        oor_d       = oor_q;
        ready_s     = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = 16'h0000;
        mem_data_s  = 16'h0000;

        case (state_q)
            S_IDLE: begin
                ready_s = 1'b1;
                if (bus.req_valid_i) begin
                    we_d    = bus.req_we_i;
                    half_d  = bus.req_half_i;
                    uns_d   = bus.req_unsigned_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    if (req_misalign_s || req_oor_s) begin
                        state_d    = S_RESP;
                        rdata_d    = 16'h0000;
                        misalign_d = req_misalign_s;
                        oor_d      = req_oor_s;
                    end else if (bus.req_we_i && bus.req_half_i) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                mem_read_s = 1'b1;
                mem_addr_s = word_index(addr_q);
                state_d    = S_CAP;
            end
            S_CAP: begin
                mem_addr_s = word_index(addr_q);
                misalign_d = 1'b0;
                oor_d      = 1'b0;
                state_d    = S_RESP;
                if (we_q) begin
                    mem_write_s = 1'b1;
                    mem_data_s  = byte_merge(bus.mem_rdata_i, wdata_q[7:0], addr_q[0]);
                    rdata_d     = 16'h0000;
                end else begin
                    rdata_d = load_extend(bus.mem_rdata_i, half_q, uns_q, addr_q[0]);
                end
            end
            S_WR: begin
                mem_write_s = 1'b1;
                mem_addr_s  = word_index(addr_q);
                mem_data_s  = wdata_q;
                rdata_d     = 16'h0000;
                misalign_d  = 1'b0;
                oor_d       = 1'b0;
                state_d     = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready_o  = ready_s;
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_rdata_o = rdata_q;
    assign bus.misalign_o   = misalign_q;
    assign bus.oor_o        = oor_q;
    assign bus.mem_addr_o   = mem_addr_s;
    assign bus.mem_data_o   = mem_data_s;
    assign bus.mem_write_o  = mem_write_s;
    assign bus.mem_read_o   = mem_read_s;

`ifdef LSU_ACCESS_CNT_EN
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] store_cnt_q, store_cnt_d;
    logic        count_s;

    // Only completed, non-faulting accesses are counted; the latched we still describes them in RESP.
    assign count_s = (state_q == S_RESP) && !misalign_q && !oor_q;

    // Access counter next-state.
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (count_s && we_q) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end else if (count_s) begin
            load_cnt_d = load_cnt_q + 16'd1;
        end else begin
            load_cnt_d = load_cnt_q;
        end
    end

    // Access counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q  <= 16'h0000;
            store_cnt_q <= 16'h0000;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_cnt_o  = load_cnt_q;
    assign store_cnt_o = store_cnt_q;
`endif

endmodule

// File: tb/tb_lsu_byte_merge.sv
// Randomized bench for lsu_byte_merge: a transaction-level model predicts per-cycle
// handshake, memory traffic and responses; a word memory with 1-cycle read sits below the unit.
module tb_lsu_byte_merge;
    localparam int MEM_WORDS = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_byte_merge_if #(.ADDR_WIDTH(16)) bus ();
`ifdef LSU_ACCESS_CNT_EN
    logic [15:0] load_cnt;
    logic [15:0] store_cnt;
`endif

    lsu_byte_merge #(.MEM_WORDS(MEM_WORDS), .ADDR_WIDTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef LSU_ACCESS_CNT_EN
        ,
        .load_cnt_o(load_cnt),
        .store_cnt_o(store_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic        half;
        logic        uns;
        logic [15:0] addr;
        logic [15:0] wdata;
    } req_t;

    req_t q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] preload(input int i);
        if (i == 32'h10) return 16'hA55A;
        if (i == 32'h1FFF) return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h3C5A;
    endfunction

    // Word memory: registered read, zero when the previous cycle had no read enable.
    logic [15:0] mem [0:MEM_WORDS-1];
    logic [15:0] ref_mem [0:MEM_WORDS-1];
    logic init_done = 1'b0;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= preload(i);
            init_done <= 1'b1;
            bus.mem_rdata_i <= 16'h0000;
        end else begin
            bus.mem_rdata_i <= (bus.mem_read_o && bus.mem_addr_o < 16'(MEM_WORDS))
                               ? mem[bus.mem_addr_o[12:0]] : 16'h0000;
            if (bus.mem_write_o && bus.mem_addr_o < 16'(MEM_WORDS))
                mem[bus.mem_addr_o[12:0]] <= bus.mem_data_o;
        end
    end

    // Transaction model: cycle labels of the expected events of the current transaction.
    int e_rd = -100, e_wr = -100, e_resp = -100;
    logic [15:0] e_addr = 16'h0, e_wdata = 16'h0;
    logic [15:0] prev_rdata = 16'h0, new_rdata = 16'h0;
    logic prev_mis = 1'b0, new_mis = 1'b0, prev_oor = 1'b0, new_oor = 1'b0;
    logic e_load = 1'b0, e_fault = 1'b0;
    int done_loads = 0, done_stores = 0;
    bit chk_en = 1'b0;
    int n_sched = 0, n_resp = 0;
    logic [15:0] act_rdata[$];
    logic act_mis[$];
    logic act_oor[$];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the clock edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check1("req_ready", bus.req_ready_o, cyc > e_resp);
            check1("resp_valid", bus.resp_valid_o, cyc == e_resp);
            check1("mem_read", bus.mem_read_o, cyc == e_rd);
            if (cyc == e_rd) check16("mem_read_addr", bus.mem_addr_o, e_addr);
            check1("mem_write", bus.mem_write_o, cyc == e_wr);
            if (cyc == e_wr) begin
                check16("mem_write_addr", bus.mem_addr_o, e_addr);
                check16("mem_write_data", bus.mem_data_o, e_wdata);
            end
            check16("resp_rdata", bus.resp_rdata_o, (cyc >= e_resp) ? new_rdata : prev_rdata);
            check1("misalign", bus.misalign_o, (cyc >= e_resp) ? new_mis : prev_mis);
            check1("oor", bus.oor_o, (cyc >= e_resp) ? new_oor : prev_oor);
`ifdef LSU_ACCESS_CNT_EN
            check16("load_cnt", load_cnt, 16'(done_loads));
            check16("store_cnt", store_cnt, 16'(done_stores));
`endif
            if (bus.resp_valid_o) begin
                act_rdata.push_back(bus.resp_rdata_o);
                act_mis.push_back(bus.misalign_o);
                act_oor.push_back(bus.oor_o);
                n_resp++;
            end
            if (cyc == e_resp && !e_fault) begin
                if (e_load) done_loads++;
                else done_stores++;
            end
        end
    end

    // Called in an idle cycle: the request is accepted at the next edge.
    task automatic drive_and_schedule(input req_t r);
        int          acc;
        logic [14:0] idx;
        logic [15:0] w;
        logic [7:0]  b;
        bus.req_valid_i    = 1'b1;
        bus.req_we_i       = r.we;
        bus.req_half_i     = r.half;
        bus.req_unsigned_i = r.uns;
        bus.req_addr_i     = r.addr;
        bus.req_wdata_i    = r.wdata;
        acc = cyc + 1;
        idx = r.addr[15:1];
        prev_rdata = new_rdata;
        prev_mis   = new_mis;
        prev_oor   = new_oor;
        e_addr     = {1'b0, idx};
        new_mis    = r.half && r.addr[0];
        new_oor    = int'(idx) >= MEM_WORDS;
        e_fault    = new_mis || new_oor;
        e_load     = !r.we;
        new_rdata  = 16'h0000;
        e_rd = -100;
        e_wr = -100;
        if (e_fault) begin
            e_resp = acc;
        end else begin
            w = ref_mem[idx[12:0]];
            b = 8'((w >> (r.addr[0] ? 8 : 0)) & 16'h00FF);
            if (!r.we) begin
                e_rd   = acc;
                e_resp = acc + 2;
                if (r.half) new_rdata = w;
                else if (r.uns || b < 8'd128) new_rdata = 16'(b);
                else new_rdata = 16'(b) + 16'hFF00;
            end else if (r.half) begin
                e_wr    = acc;
                e_resp  = acc + 1;
                e_wdata = r.wdata;
                ref_mem[idx[12:0]] = r.wdata;
            end else begin
                e_rd    = acc;
                e_wr    = acc + 1;
                e_resp  = acc + 2;
                e_wdata = r.addr[0] ? {r.wdata[7:0], w[7:0]} : {w[15:8], r.wdata[7:0]};
                ref_mem[idx[12:0]] = e_wdata;
            end
        end
        n_sched++;
    endtask

    task automatic drive_garbage(input bit hold);
        bus.req_valid_i    = hold ? 1'b1 : 1'($urandom);
        bus.req_we_i       = 1'($urandom);
        bus.req_half_i     = 1'($urandom);
        bus.req_unsigned_i = 1'($urandom);
        bus.req_addr_i     = 16'($urandom);
        bus.req_wdata_i    = 16'($urandom);
    endtask

    task automatic run_queue(input bit hold);
        int guard = 0;
        while ((q.size() > 0 || cyc <= e_resp) && guard < 5000) begin
            @(negedge clk);
            if (cyc > e_resp) begin
                if (q.size() > 0) drive_and_schedule(q.pop_front());
                else bus.req_valid_i = 1'b0;
            end else begin
                drive_garbage(hold);
            end
            guard++;
        end
        if (guard >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_queue timeout: got %0d cycles, expected fewer than 5000", guard);
        end
    endtask

    function automatic req_t mk(input logic we, input logic half, input logic uns,
                                input logic [15:0] addr, input logic [15:0] wdata);
        req_t r;
        r.we = we; r.half = half; r.uns = uns; r.addr = addr; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        int   sel;
        sel = $urandom_range(0, 9);
        r.we    = 1'($urandom);
        r.half  = 1'($urandom);
        r.uns   = 1'($urandom);
        r.wdata = 16'($urandom);
        if (sel == 0) r.addr = 16'($urandom_range(32'h4000, 32'hFFFF));
        else if (sel == 1) r.addr = 16'h3FFE + 16'($urandom_range(0, 1));
        else r.addr = 16'($urandom_range(0, 255));
        return r;
    endfunction

    initial begin
        int bad;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = preload(i);
        bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_half_i = 1'b0;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 16'h0; bus.req_wdata_i = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset_ready", bus.req_ready_o, 1'b1);
        check1("reset_resp_valid", bus.resp_valid_o, 1'b0);
        check16("reset_rdata", bus.resp_rdata_o, 16'h0000);
        check1("reset_misalign", bus.misalign_o, 1'b0);
        check1("reset_oor", bus.oor_o, 1'b0);
        check1("reset_mem_read", bus.mem_read_o, 1'b0);
        check1("reset_mem_write", bus.mem_write_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0021, 16'h0000));
        q.push_back(mk(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0000));
        q.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0000));
        q.push_back(mk(1'b1, 1'b1, 1'b0, 16'h0040, 16'h1234));
        q.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0041, 16'hABEF));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0000));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h4000, 16'h0000));
        q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h3FFE, 16'h0000));
        run_queue(1'b0);

        check16("pin_byte_signed_hi", act_rdata[0], 16'hFFA5);
        check16("pin_byte_unsigned_hi", act_rdata[1], 16'h00A5);
        check16("pin_byte_signed_lo", act_rdata[2], 16'h005A);
        check16("pin_half_store_resp", act_rdata[3], 16'h0000);
        check16("pin_rmw_load", act_rdata[5], 16'hEF34);
        check1("pin_misalign_flag", act_mis[6], 1'b1);
        check16("pin_misalign_rdata", act_rdata[6], 16'h0000);
        check1("pin_oor_flag", act_oor[7], 1'b1);
        check1("pin_last_word_oor", act_oor[8], 1'b0);
        check16("pin_last_word_data", act_rdata[8], 16'hBEEF);
        check16("pin_mem_word_20", mem[16'h0020], 16'hEF34);
`ifdef LSU_ACCESS_CNT_EN
        check16("pin_load_cnt", load_cnt, 16'd5);
        check16("pin_store_cnt", store_cnt, 16'd2);
`endif

        for (int i = 0; i < 150; i++) q.push_back(rand_req());
        run_queue(1'b0);
        for (int i = 0; i < 150; i++) q.push_back(rand_req());
        run_queue(1'b1);
        check16("one_accept_per_txn", 16'(n_resp), 16'(n_sched));

        // Reset in the middle of a byte store's write cycle.
        @(negedge clk);
        chk_en = 1'b0;
        bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_half_i = 1'b0;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 16'h0101; bus.req_wdata_i = 16'h0077;
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
        check1("rst_test_read", bus.mem_read_o, 1'b1);
        @(posedge clk);
        #1;
        check1("rst_test_cap_write", bus.mem_write_o, 1'b1);
        rst = 1'b1;
        #1;
        check1("rst_test_write_drop", bus.mem_write_o, 1'b0);
        check1("rst_test_ready", bus.req_ready_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check16("rst_test_word_kept", mem[16'h0080], ref_mem[16'h0080]);
        check1("rst_test_ready_after", bus.req_ready_o, 1'b1);
        check16("rst_test_rdata", bus.resp_rdata_o, 16'h0000);
        e_rd = -100; e_wr = -100; e_resp = -100;
        prev_rdata = 16'h0; new_rdata = 16'h0;
        prev_mis = 1'b0; new_mis = 1'b0; prev_oor = 1'b0; new_oor = 1'b0;
        done_loads = 0; done_stores = 0;
        chk_en = 1'b1;

        q.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000));
        for (int i = 0; i < 40; i++) q.push_back(rand_req());
        run_queue(1'b1);

        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check16("mem_image", 16'(bad), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_byte_merge.md
Name: lsu_byte_merge

Overview:
- Load/store unit directly upstream of the 16-bit word data memory; converts byte-addressed pipeline requests into word-granular memory accesses.
- Byte stores use read-modify-write. Loads are sign- or zero-extended.
- Misaligned halfword accesses and out-of-range addresses are flagged and suppressed, not forwarded.
- Memory has 1-cycle registered read; read data is 0 in any cycle not preceded by a read enable.

Parameters:
- MEM_WORDS, 8192, depth of the downstream word memory; word indices >= MEM_WORDS are out of range.
- ADDR_WIDTH, 16, byte-address width of requests.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid_i  input  1  request present
- req_ready_o  output  1  unit can accept request (IDLE only)
- req_we_i  input  1  1=store, 0=load
- req_half_i  input  1  1=halfword, 0=byte
- req_unsigned_i  input  1  load zero-extend (1) / sign-extend (0); ignored for stores
- req_addr_i  input  ADDR_WIDTH  byte address
- req_wdata_i  input  16  store data; byte store uses [7:0]
- resp_valid_o  output  1  one-cycle completion pulse
- resp_rdata_o  output  16  extended load data; 0 for stores and faults
- misalign_o  output  1  valid with resp: halfword at odd address
- oor_o  output  1  valid with resp: word index >= MEM_WORDS
- mem_addr_o  output  16  word index = {1'b0, addr[15:1]}
- mem_data_o  output  16  write data to memory
- mem_write_o  output  1  memory write enable
- mem_read_o  output  1  memory read enable
- mem_rdata_i  input  16  memory read data, valid the cycle after mem_read_o

Behaviour:
- Reset (async, immediate): state=IDLE.
  - All registered outputs are 0: resp_rdata_o, misalign_o, oor_o.
  - Request latches are 0.
  - mem_* outputs are 0; an in-flight write is dropped.
- States: IDLE, RD, CAP, WR, RESP. mem_* outputs are decoded from state and latches; they are 0 in IDLE and RESP.
- IDLE:
  - req_ready_o=1. Accept on req_valid_i & req_ready_o; latch we, half, unsigned, addr, wdata.
  - Fault check at accept:
    - misalign = half & addr[0].
    - oor = addr[15:1] >= MEM_WORDS.
    - Either set → RESP with flags registered, resp_rdata_o=0, no memory access. Misalign has priority; both flags may be 1.
  - Otherwise:
    - Load → RD.
    - Halfword store → WR.
    - Byte store → RD.
- RD: mem_read_o=1, mem_addr_o=word index; next state CAP.
- CAP: mem_rdata_i is valid this cycle.
  - Load: register resp_rdata_o, then → RESP.
    - Half: word as-is.
    - Byte: select [7:0] if addr[0]=0, else [15:8]; extend per unsigned.
  - Byte store: mem_write_o=1.
    - mem_data_o = mem_rdata_i with the selected byte (low if addr[0]=0, high if 1) replaced by wdata[7:0].
    - resp_rdata_o<=0; → RESP.
- WR: mem_write_o=1, mem_data_o=wdata; → RESP.
- RESP: resp_valid_o=1 for exactly one cycle; → IDLE. resp_rdata_o, misalign_o and oor_o hold until the next response is registered.
- Latency in cycles, counted from the accepting edge to the resp_valid_o cycle:
  - load: 3
  - byte store: 3
  - halfword store: 2
  - fault: 1
- Throughput: one request per latency+1 cycles; no back-to-back acceptance.
- req_valid_i is ignored outside IDLE. Request inputs are not required stable after acceptance.
- Endianness: little-endian within the word (even byte = bits [7:0]).

Optional Feature:
- Macro LSU_ACCESS_CNT_EN.
- Defined: adds outputs load_cnt_o[15:0] and store_cnt_o[15:0].
  - Each increments by 1 in the RESP cycle of a non-faulting load or store.
  - Wraps 0xFFFF→0x0000.
  - Reset to 0 asynchronously.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Preload memory word 0x0010=0xA55A. Byte load at addr 0x0021, signed → resp_valid_o 3 cycles after accept, resp_rdata_o=0xFFA5. Same access unsigned → 0x00A5. Byte load at addr 0x0020, signed → 0x005A.
- Halfword store 0x1234 at addr 0x0040 → mem_write_o exactly 1 cycle, word 0x0020=0x1234. Then byte store 0xEF at addr 0x0041 → RD, then a write of 0xEF34. A subsequent halfword load at addr 0x0040 returns 0xEF34.
- Halfword load at addr 0x0003 → no mem_read_o/mem_write_o, resp_valid_o the cycle after accept, misalign_o=1, resp_rdata_o=0.
- With MEM_WORDS=8192: load at addr 0x4000 (word 0x2000) → oor_o=1, no memory access. Load at addr 0x3FFE → normal.
- Assert rst during CAP of a byte store → mem_write_o drops the same cycle, target word unchanged, req_ready_o=1 after release. Holding req_valid_i high continuously → exactly one acceptance per completed transaction.
- LSU_ACCESS_CNT_EN: 3 loads, 2 stores, 1 misaligned access → load_cnt_o=3, store_cnt_o=2.
